// File: rtl/rv_pkg.sv
// Shared RV32I definitions: widths, special instruction words, opcodes,
// fetch state encoding and the IF/ID payload type.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  // A bubble decodes as addi x0,x0,0 so it can never disturb architectural state.
  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, pc4: '0, instr: NOP, valid: 1'b0};

  function automatic logic is_halt_instr(input logic [31:0] w);
    return (w == ECALL) || (w == EBREAK);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with load/flush/hold; reset and flush both yield a bubble.
module if_id_reg
  import rv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // Flush wins over load; neither asserted means hold.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_q <= IF_ID_BUBBLE;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch: PC and next-PC selection, IF/ID register,
// ECALL/EBREAK drain-and-halt sequencing and a fetched-instruction counter.
module if_stage
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned     DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic [31:0]     if_id_instr_o,
  output logic            if_id_valid_o,
  output logic            halted_o,
  output logic            misalign_o,
  output logic [31:0]     fetch_count_o
);

  localparam int unsigned DRAIN_W = 3;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [XLEN-1:0]   w_pc4;
  logic [DRAIN_W-1:0] r_drain;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic              r_halted;
  logic              r_misalign;
  logic              w_misalign_nxt;
  logic [31:0]       r_fetch_count;
  logic              w_count_inc;
  logic              w_load;
  logic              w_flush;
  if_id_t            w_if_id_d;
  if_id_t            w_if_id_q;

  assign w_pc4     = r_pc + XLEN'(4);
  assign w_if_id_d = '{pc: r_pc, pc4: w_pc4, instr: imem_rdata_i, valid: 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Priority inside RUN/DRAIN: redirect > stall > normal; HALT ignores everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_drain_nxt    = r_drain;
    w_misalign_nxt = 1'b0;
    w_count_inc    = 1'b0;
    w_load         = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      RUN, DRAIN: begin
        if (redirect_i) begin
          w_state_nxt    = RUN;
          w_pc_nxt       = {redirect_pc_i[XLEN-1:2], 2'b00};
          w_flush        = 1'b1;
          w_misalign_nxt = (redirect_pc_i[1:0] != 2'b00);
        end else if (!stall_i) begin
          if (r_state == RUN) begin
            w_load      = 1'b1;
            w_count_inc = 1'b1;
            if (is_halt_instr(imem_rdata_i)) begin
              w_state_nxt = DRAIN;
              w_drain_nxt = DRAIN_W'(DRAIN_CYCLES);
            end else begin
              w_pc_nxt = w_pc4;
            end
          end else begin
            w_flush     = 1'b1;
            w_drain_nxt = r_drain - DRAIN_W'(1);
            if (r_drain == DRAIN_W'(1)) begin
              w_state_nxt = HALT;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_drain       <= '0;
      r_halted      <= 1'b0;
      r_misalign    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_drain    <= w_drain_nxt;
      r_halted   <= (w_state_nxt == HALT);
      r_misalign <= w_misalign_nxt;
      if (w_count_inc) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_d     (w_if_id_d),
    .o_q     (w_if_id_q)
  );

  assign imem_addr_o   = r_pc;
  assign if_id_pc_o    = w_if_id_q.pc;
  assign if_id_pc4_o   = w_if_id_q.pc4;
  assign if_id_instr_o = w_if_id_q.instr;
  assign if_id_valid_o = w_if_id_q.valid;
  assign halted_o      = r_halted;
  assign misalign_o    = r_misalign;
  assign fetch_count_o = r_fetch_count;

endmodule
